aes128_inv_key_scheduler: RTL and testbench
===========================================

# aes128_inv_key_scheduler

Sequential AES-128 inverse key scheduler for the decrypt datapath. Takes the round-10 key and produces round keys 10 down to 0, one per output handshake, using the inverse key-expansion recursion. This lets the decrypt core step round keys in decryption order without storing all 11 keys. It sits between key load and the inverse-round pipeline.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- inValid  in  1  inKey is valid
- inReady  out  1  block can accept a key; equals (state == IDLE)
- inKey  in  128  round-10 key; word w40 in bits [127:96]. With AES128_INVKS_FWD_EN defined: the cipher key (round 0).
- outValid  out  1  outKey/outRound are valid
- outReady  in  1  consumer accepts the current key
- outKey  out  128  current round key, same word order as inKey
- outRound  out  4  round number of outKey, 10 down to 0
- outLast  out  1  high with outValid when outRound == 0
- busy  out  1  high in any state other than IDLE

## Operation
- States:
  - IDLE: inReady = 1.
    - Without AES128_INVKS_FWD_EN: on an input handshake, go to EMIT.
    - With AES128_INVKS_FWD_EN: on an input handshake, go to FWD.
  - FWD (only with AES128_INVKS_FWD_EN): the key register steps forward one round per cycle. After 10 cycles the register holds the round-10 key; then go to EMIT.
  - EMIT: outValid = 1 while holding round r.
    - On an output handshake (outValid && outReady) with r > 0, load the round r-1 key and set outRound to r-1, in the same edge.
    - On an output handshake with r == 0, go to IDLE.
- Inverse step, from round i key {a,b,c,d} to round i-1 key {a',b',c',d'}:
  - d' = d^c
  - c' = c^b
  - b' = b^a
  - a' = a ^ SubWord(RotWord(d')) ^ {Rcon[i],24'h0}
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- RotWord: {B0,B1,B2,B3} -> {B1,B2,B3,B0}. SubWord applies the forward AES S-box to each byte.
- All XOR is bitwise at 32-bit width; there is no carry.
- inValid outside IDLE is ignored; inKey is not sampled.
- While outValid && !outReady, outKey, outRound and outLast hold stable.
- Reset (asserted at any time, including mid-sequence) aborts the sequence and forces:
  - state IDLE, outValid 0, outKey 0, outRound 0, outLast 0, busy 0
  - inReady 1, since inReady follows the state

## Timing
- Latency, input handshake edge to outValid high:
  - without AES128_INVKS_FWD_EN: 1 cycle
  - with AES128_INVKS_FWD_EN: 11 cycles
- With outReady tied high, one key per cycle. Round 10 through round 0 complete in 11 consecutive cycles.
- inReady rises the cycle after the round-0 handshake. The minimum gap between accepted keys is 12 cycles without AES128_INVKS_FWD_EN and 22 cycles with it.
- Combinational critical path: 2 XORs, 4 S-box lookups and a 3-input XOR per cycle.
- Outputs are registered. inReady and busy decode directly from the state register.

## Configuration
- Macro: AES128_INVKS_FWD_EN.
- Defined:
  - inKey is the cipher key.
  - The FWD state and the forward step (a' = a ^ SubWord(RotWord(d)) ^ Rcon[i+1], then b' = b^a', c' = c^b', d' = d^c') are compiled in.
  - The output sequence is unchanged (round 10 down to 0).
- Undefined:
  - FWD and the forward step logic are absent.
  - inKey must be the round-10 key.

## Structure
- Package aes128_pkg holds:
  - the state enum (IDLE, FWD, EMIT)
  - the Rcon table as a 10-entry constant
  - the S-box function
  - the constant LAST_ROUND = 4'd10
- Sub-module aes128_key_step: combinational single-round step with inputs key, round and dir (forward/inverse), output next key. Instantiated once and shared by the FWD and EMIT states.
- The top level holds the FSM, the 128-bit key register, the round counter and the handshake logic.

## Test plan
- Basic sequence (FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c), outReady = 1:
  - stimulus: inKey = d014f9a8c9ee2589e13f0cc8b6630ca6
  - response: round 10 = that key; round 9 = ac7766f319fadc2128d12941575c006e; round 1 = a0fafe1788542cb123a339392a6c7605; round 0 = 2b7e1516... with outLast = 1
- Backpressure: drop outReady for 3 cycles at round 7 -> outKey and outRound = 7 stay stable; the sequence resumes with round 6 and no keys are lost or duplicated.
- Input while busy: pulse inValid with a different key during EMIT -> it is ignored; the sequence matches the first scenario and inReady = 0 throughout.
- Reset mid-operation: assert rst asynchronously at round 4 -> all outputs go to 0 immediately. After release, a new key is accepted and round 10 follows in 1 cycle.
- Back-to-back keys: assert inValid continuously -> the second key is accepted the cycle after the round-0 handshake, with exactly 11 output keys per input.
- AES128_INVKS_FWD_EN build: inKey = 2b7e151628aed2a6abf7158809cf4f3c -> outValid rises after 11 cycles with d014f9a8c9ee2589e13f0cc8b6630ca6; the rest of the sequence is identical to the first scenario.

Source files
------------

// File: rtl/aes128_pkg.sv
// rtl/aes128_pkg.sv - shared state/direction types, Rcon table and S-box for the AES-128 key scheduler
// Contents: state_t (IDLE, FWD, EMIT), dir_t (DIR_INV, DIR_FWD), LAST_ROUND,
//           RCON table, rcon_of(), sbox(), sub_rot_word().
package aes128_pkg;

   typedef enum logic [1:0] {IDLE, FWD, EMIT} state_t;
   typedef enum logic {DIR_INV, DIR_FWD} dir_t;

   localparam logic [3:0] LAST_ROUND = 4'd10;

   // RCON[k] is Rcon for round k+1.
   localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

   // Forward S-box, entry 0x00 in the top byte.
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Rcon for rounds 1..10; zero outside that range.
   function automatic logic [7:0] rcon_of(input logic [3:0] round);
      logic [3:0] idx;
      idx = round - 4'd1;
      if (round >= 4'd1 && round <= LAST_ROUND)
         rcon_of = RCON[idx];
      else
         rcon_of = 8'h00;
   endfunction

   // Byte x sits at bit offset (255 - x) * 8, i.e. {~x, 3'b000}.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      sbox = SBOX_TABLE[{~x, 3'b000} +: 8];
   endfunction

   // SubWord(RotWord(w)) with B0 in the top byte.
   function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
      sub_rot_word = {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
   endfunction

endpackage

// File: rtl/aes128_key_step.sv
// rtl/aes128_key_step.sv - combinational single-round AES-128 key-expansion step (forward or inverse)
// Ports: key      in  128  round key i, word a in [127:96]
//        round    in  4    round number i of key
//        dir      in  1    DIR_INV: produce key i-1; DIR_FWD: produce key i+1
//        next_key out 128  stepped key, same word order
module aes128_key_step
   import aes128_pkg::*;
(
   input  logic [127:0] key,
   input  logic [3:0]   round,
   input  dir_t         dir,
   output logic [127:0] next_key
);

   logic [31:0] a, b, c, d;
   logic [31:0] d_inv;
   logic [31:0] sub_src;
   logic [31:0] a_new;
   logic [7:0]  rc;

   assign {a, b, c, d} = key;
   assign d_inv = d ^ c;

   // One S-box bank shared by both directions: the inverse step feeds it
   // the recovered d', the forward step feeds it the current d.
   always_comb begin
      sub_src = d_inv;
      rc      = rcon_of(round);
      if (dir == DIR_FWD) begin
         sub_src = d;
         rc      = rcon_of(round + 4'd1);
      end
   end

   assign a_new = a ^ sub_rot_word(sub_src) ^ {rc, 24'h000000};

   always_comb begin
      if (dir == DIR_FWD)
         next_key = {a_new, b ^ a_new, c ^ b ^ a_new, d ^ c ^ b ^ a_new};
      else
         next_key = {a_new, b ^ a, c ^ b, d_inv};
   end

endmodule

// File: rtl/aes128_inv_key_scheduler.sv
// rtl/aes128_inv_key_scheduler.sv - sequential AES-128 inverse key scheduler emitting round keys 10 down to 0
// Ports: clk, rst (async, active high)
//        inValid/inReady/inKey       key load handshake (inReady = state IDLE)
//        outValid/outReady/outKey    round key output handshake
//        outRound, outLast           round number of outKey, high at round 0
//        busy                        state is not IDLE
// Macro: AES128_INVKS_FWD_EN - inKey is the cipher key; a FWD phase expands it
//        to the round-10 key before emission.
module aes128_inv_key_scheduler
   import aes128_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         inValid,
   output logic         inReady,
   input  logic [127:0] inKey,
   output logic         outValid,
   input  logic         outReady,
   output logic [127:0] outKey,
   output logic [3:0]   outRound,
   output logic         outLast,
   output logic         busy
);

   state_t       state;
   logic [127:0] key_q;
   logic [3:0]   round_q;
   logic         valid_q;
   logic         last_q;
   dir_t         step_dir;
   logic [127:0] step_key;

`ifdef AES128_INVKS_FWD_EN
   assign step_dir = (state == FWD) ? DIR_FWD : DIR_INV;
`else
   assign step_dir = DIR_INV;
`endif

   aes128_key_step u_step (
      .key      (key_q),
      .round    (round_q),
      .dir      (step_dir),
      .next_key (step_key)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         key_q   <= '0;
         round_q <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (inValid) begin
                  key_q <= inKey;
`ifdef AES128_INVKS_FWD_EN
                  round_q <= 4'd0;
                  state   <= FWD;
`else
                  round_q <= LAST_ROUND;
                  valid_q <= 1'b1;
                  last_q  <= 1'b0;
                  state   <= EMIT;
`endif
               end
            end
`ifdef AES128_INVKS_FWD_EN
            FWD: begin
               key_q   <= step_key;
               round_q <= round_q + 4'd1;
               // Loading round 10 this edge: present it next cycle.
               if (round_q == LAST_ROUND - 4'd1) begin
                  valid_q <= 1'b1;
                  last_q  <= 1'b0;
                  state   <= EMIT;
               end
            end
`endif
            EMIT: begin
               if (outReady) begin
                  if (round_q == 4'd0) begin
                     valid_q <= 1'b0;
                     last_q  <= 1'b0;
                     state   <= IDLE;
                  end else begin
                     key_q   <= step_key;
                     round_q <= round_q - 4'd1;
                     last_q  <= (round_q == 4'd1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign inReady  = (state == IDLE);
   assign busy     = (state != IDLE);
   assign outValid = valid_q;
   assign outKey   = key_q;
   assign outRound = round_q;
   assign outLast  = last_q;

endmodule

// File: tb/tb_aes128_inv_key_scheduler.sv
// tb/tb_aes128_inv_key_scheduler.sv - directed self-checking bench for aes128_inv_key_scheduler (FIPS-197 key)
module tb_aes128_inv_key_scheduler;

   typedef struct {
      logic [3:0]   round;
      logic [127:0] key;
      logic         last;
   } vec_t;

   // FIPS-197 A.1 round keys for 2b7e151628aed2a6abf7158809cf4f3c, index = round.
   localparam logic [127:0] RK [11] = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c,
      128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f,
      128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00,
      128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd,
      128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f,
      128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6
   };

`ifdef AES128_INVKS_FWD_EN
   localparam logic [127:0] LOAD_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
`else
   localparam logic [127:0] LOAD_KEY = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
`endif

   logic         clk;
   logic         rst;
   logic         inValid;
   logic         inReady;
   logic [127:0] inKey;
   logic         outValid;
   logic         outReady;
   logic [127:0] outKey;
   logic [3:0]   outRound;
   logic         outLast;
   logic         busy;

   int   tests;
   int   fails;
   vec_t tbl [11];

   aes128_inv_key_scheduler dut (
      .clk      (clk),
      .rst      (rst),
      .inValid  (inValid),
      .inReady  (inReady),
      .inKey    (inKey),
      .outValid (outValid),
      .outReady (outReady),
      .outKey   (outKey),
      .outRound (outRound),
      .outLast  (outLast),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic check_idle(input string name);
      check({name, "_valid"}, {127'd0, outValid}, 128'd0);
      check({name, "_ready"}, {127'd0, inReady}, 128'd1);
      check({name, "_busy"}, {127'd0, busy}, 128'd0);
   endtask

   // Load a key and wait until the first round key should be presented.
   task automatic accept(input logic [127:0] k, input bit keep);
      inKey   = k;
      inValid = 1'b1;
      check("accept_ready", {127'd0, inReady}, 128'd1);
      step();
      if (!keep) inValid = 1'b0;
`ifdef AES128_INVKS_FWD_EN
      for (int n = 0; n < 10; n++) begin
         check("fwd_novalid", {127'd0, outValid}, 128'd0);
         check("fwd_busy", {127'd0, busy}, 128'd1);
         step();
      end
`endif
      check("latency_valid", {127'd0, outValid}, 128'd1);
   endtask

   // Walk the 11 output keys; optional 3-cycle stall at stall_round and
   // an optional foreign key pulse while emitting.
   task automatic run_seq(input int stall_round, input bit pulse);
      for (int i = 0; i < 11; i++) begin
         check("seq_valid", {127'd0, outValid}, 128'd1);
         check("seq_round", {124'd0, outRound}, {124'd0, tbl[i].round});
         check("seq_key", outKey, tbl[i].key);
         check("seq_last", {127'd0, outLast}, {127'd0, tbl[i].last});
         check("seq_ready_low", {127'd0, inReady}, 128'd0);
         if (int'(tbl[i].round) == stall_round) begin
            outReady = 1'b0;
            for (int s = 0; s < 3; s++) begin
               step();
               check("stall_valid", {127'd0, outValid}, 128'd1);
               check("stall_round", {124'd0, outRound}, {124'd0, tbl[i].round});
               check("stall_key", outKey, tbl[i].key);
               check("stall_last", {127'd0, outLast}, 128'd0);
            end
            outReady = 1'b1;
         end
         if (pulse && i == 3) begin
            inValid = 1'b1;
            inKey   = ~LOAD_KEY;
         end
         step();
         inValid = 1'b0;
      end
      check_idle("seq_end");
   endtask

   initial begin
      tests    = 0;
      fails    = 0;
      rst      = 1'b1;
      inValid  = 1'b0;
      inKey    = '0;
      outReady = 1'b1;
      for (int i = 0; i < 11; i++) begin
         tbl[i].round = 4'(10 - i);
         tbl[i].key   = RK[10 - i];
         tbl[i].last  = (i == 10);
      end

      // Reset state
      step();
      step();
      check("rst_valid", {127'd0, outValid}, 128'd0);
      check("rst_key", outKey, 128'd0);
      check("rst_round", {124'd0, outRound}, 128'd0);
      check("rst_last", {127'd0, outLast}, 128'd0);
      check("rst_busy", {127'd0, busy}, 128'd0);
      check("rst_ready", {127'd0, inReady}, 128'd1);
      rst = 1'b0;
      step();

      // Basic sequence
      accept(LOAD_KEY, 1'b0);
      run_seq(-1, 1'b0);

      // Backpressure at round 7
      accept(LOAD_KEY, 1'b0);
      run_seq(7, 1'b0);

      // Input while busy is ignored
      accept(LOAD_KEY, 1'b0);
      run_seq(-1, 1'b1);

      // Asynchronous reset at round 4
      accept(LOAD_KEY, 1'b0);
      for (int i = 0; i < 6; i++) step();
      check("pre_rst_round", {124'd0, outRound}, 128'd4);
      #2;
      rst = 1'b1;
      #1;
      check("arst_valid", {127'd0, outValid}, 128'd0);
      check("arst_key", outKey, 128'd0);
      check("arst_round", {124'd0, outRound}, 128'd0);
      check("arst_last", {127'd0, outLast}, 128'd0);
      check("arst_busy", {127'd0, busy}, 128'd0);
      check("arst_ready", {127'd0, inReady}, 128'd1);
      step();
      rst = 1'b0;
      step();
      accept(LOAD_KEY, 1'b0);
      check("post_rst_round", {124'd0, outRound}, 128'd10);
      check("post_rst_key", outKey, RK[10]);
      run_seq(-1, 1'b0);

      // Back-to-back keys with inValid held high
      accept(LOAD_KEY, 1'b1);
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 11; i++) begin
            check("b2b_valid", {127'd0, outValid}, 128'd1);
            check("b2b_round", {124'd0, outRound}, {124'd0, tbl[i].round});
            check("b2b_key", outKey, tbl[i].key);
            step();
         end
         check("b2b_gap_ready", {127'd0, inReady}, 128'd1);
         check("b2b_gap_valid", {127'd0, outValid}, 128'd0);
         if (k == 1) inValid = 1'b0;
         step();
         if (k == 0) begin
            check("b2b_reaccept", {127'd0, busy}, 128'd1);
`ifdef AES128_INVKS_FWD_EN
            for (int n = 0; n < 10; n++) step();
`endif
         end
      end
      check_idle("b2b_end");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
